uart_xlink_switch: RTL

Parametrised N-node UART cross-link fabric for the bus-bridge demo system. It generalises the fixed two-node master/slave UART crossing to NUM_NODES nodes. Each node's master TX can be routed at run time to any other node's slave RX, and that slave's TX returns to the master's RX. Route changes go through a config handshake and are applied only when every affected serial line is between frames, so no UART frame is ever cut mid-transfer.

---
 rtl/uart_xlink_pkg.sv | 8 +
 rtl/uart_frame_tracker.sv | 45 ++++
 rtl/uart_xlink_switch.sv | 106 ++++++++++
 3 files changed

// File: rtl/uart_xlink_pkg.sv
// uart_xlink_pkg: shared state enums and frame-length helper for the UART cross-link switch
package uart_xlink_pkg;
  typedef enum logic [1:0] {CFG_IDLE, CFG_WAIT, CFG_APPLY, CFG_ERR} cfg_state_t;
  typedef enum logic {TRK_IDLE, TRK_BUSY} trk_state_t;
  function automatic int frame_cycles(input int bits, input int clks);
    return bits * clks;
  endfunction
endpackage

// File: rtl/uart_frame_tracker.sv
// uart_frame_tracker: flags a serial line busy from its start edge until the frame (or break) ends
module uart_frame_tracker
  import uart_xlink_pkg::*;
#(
  parameter int UART_CLOCKS_PER_PULSE = 5208,
  parameter int FRAME_BITS = 10
) (
  input  logic clk,
  input  logic rstn,
  input  logic line,
  output logic busy
);
  localparam int FC = frame_cycles(FRAME_BITS, UART_CLOCKS_PER_PULSE);
  localparam int CW = $clog2(FC + 1);
  trk_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic prev, fall;
  assign fall = prev & ~line;
  // a start edge counts as busy in the same cycle so a concurrent reroute is held off
  assign busy = (state == TRK_BUSY) || fall;
  // state, frame counter and previous line sample
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= TRK_IDLE;
      cnt <= '0;
      prev <= 1'b1;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      prev <= line;
    end
  end
  // start on falling edge, count one frame, then wait for the line to be high (break)
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (state == TRK_IDLE) begin
      if (fall) begin
        state_nx = TRK_BUSY;
        cnt_nx = CW'(FC - 1);
      end
    end else if (cnt != '0) cnt_nx = cnt - 1'b1;
    else if (line) state_nx = TRK_IDLE;
  end
endmodule

// File: rtl/uart_xlink_switch.sv
// uart_xlink_switch: N-node UART master/slave cross-link with frame-safe runtime rerouting
// Define XLINK_LOOPBACK_EN to allow a node's master TX to be routed to its own slave RX.
module uart_xlink_switch
  import uart_xlink_pkg::*;
#(
  parameter int NUM_NODES = 4,
  parameter int UART_CLOCKS_PER_PULSE = 5208,
  parameter int FRAME_BITS = 10,
  localparam int IDX_W = $clog2(NUM_NODES)
) (
  input  logic clk,
  input  logic rstn,
  input  logic [NUM_NODES-1:0] m_u_tx_in,
  input  logic [NUM_NODES-1:0] s_u_tx_in,
  output logic [NUM_NODES-1:0] m_u_rx_out,
  output logic [NUM_NODES-1:0] s_u_rx_out,
  input  logic cfg_valid,
  output logic cfg_ready,
  input  logic [IDX_W-1:0] cfg_node,
  input  logic [IDX_W-1:0] cfg_target,
  input  logic cfg_disconnect,
  output logic cfg_done,
  output logic cfg_err,
  output logic [2*NUM_NODES-1:0] line_busy
);
  logic [NUM_NODES-1:0] rm, rs, m_busy, s_busy, tgt_v, own_v;
  logic [IDX_W-1:0] tgt [NUM_NODES];
  logic [IDX_W-1:0] own [NUM_NODES];
  logic [IDX_W-1:0] rq_node, rq_tgt;
  logic rq_disc, bad, self_bad, wait_busy;
  cfg_state_t state, state_nx;
`ifdef XLINK_LOOPBACK_EN
  assign self_bad = 1'b0;
`else
  assign self_bad = cfg_target == cfg_node;
`endif
  assign bad = int'(cfg_node) >= NUM_NODES || (!cfg_disconnect && (int'(cfg_target) >= NUM_NODES ||
               (own_v[cfg_target] && own[cfg_target] != cfg_node) || self_bad));
  assign wait_busy = m_busy[rq_node] || (tgt_v[rq_node] && s_busy[tgt[rq_node]]) || (!rq_disc && s_busy[rq_tgt]);
  assign line_busy = {s_busy, m_busy};
  for (genvar i = 0; i < NUM_NODES; i++) begin : g_trk
    uart_frame_tracker #(.UART_CLOCKS_PER_PULSE(UART_CLOCKS_PER_PULSE), .FRAME_BITS(FRAME_BITS)) u_m (
      .clk(clk), .rstn(rstn), .line(rm[i]), .busy(m_busy[i]));
    uart_frame_tracker #(.UART_CLOCKS_PER_PULSE(UART_CLOCKS_PER_PULSE), .FRAME_BITS(FRAME_BITS)) u_s (
      .clk(clk), .rstn(rstn), .line(rs[i]), .busy(s_busy[i]));
  end
  // input capture and registered crossbar; unrouted outputs idle high
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rm <= '1;
      rs <= '1;
      m_u_rx_out <= '1;
      s_u_rx_out <= '1;
    end else begin
      rm <= m_u_tx_in;
      rs <= s_u_tx_in;
      for (int i = 0; i < NUM_NODES; i++) begin
        m_u_rx_out[i] <= tgt_v[i] ? rs[tgt[i]] : 1'b1;
        s_u_rx_out[i] <= own_v[i] ? rm[own[i]] : 1'b1;
      end
    end
  end
  // config state register and request latch
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= CFG_IDLE;
      rq_node <= '0;
      rq_tgt <= '0;
      rq_disc <= 1'b0;
    end else begin
      state <= state_nx;
      if (cfg_valid && cfg_ready) begin
        rq_node <= cfg_node;
        rq_tgt <= cfg_target;
        rq_disc <= cfg_disconnect;
      end
    end
  end
  // config FSM: validate, wait for all involved lines to be between frames, then apply
  always_comb begin
    cfg_ready = state == CFG_IDLE;
    cfg_done = state == CFG_APPLY;
    cfg_err = state == CFG_ERR;
    state_nx = state == CFG_IDLE ? (cfg_valid ? (bad ? CFG_ERR : CFG_WAIT) : CFG_IDLE) :
               state == CFG_WAIT ? (wait_busy ? CFG_WAIT : CFG_APPLY) : CFG_IDLE;
  end
  // route map: pairwise cross on reset; old entry cleared before the new one is written
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        tgt[i] <= IDX_W'(i ^ 1);
        own[i] <= IDX_W'(i ^ 1);
      end
      tgt_v <= '1;
      own_v <= '1;
    end else if (state == CFG_APPLY) begin
      if (tgt_v[rq_node]) own_v[tgt[rq_node]] <= 1'b0;
      tgt_v[rq_node] <= !rq_disc;
      if (!rq_disc) begin
        tgt[rq_node] <= rq_tgt;
        own[rq_tgt] <= rq_node;
        own_v[rq_tgt] <= 1'b1;
      end
    end
  end
endmodule
